// File: rtl/core_mem_arb_pkg.sv
// core_mem_arb_pkg
// Shared types and constants for the instruction/data memory arbiter.
//   port_id_e       : identifies which core port owns a transaction
//   DATA_PRIO_RR    : round-robin tie breaking between the two ports
//   DATA_PRIO_FIXED : data port always wins a tie
package core_mem_arb_pkg;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_id_e;

  localparam int DATA_PRIO_RR    = 0;
  localparam int DATA_PRIO_FIXED = 1;

endpackage

// File: rtl/core_mem_arb_id_fifo.sv
// core_mem_arb_id_fifo
// In-order FIFO of port IDs, one entry per accepted-but-unanswered memory
// transaction. The head entry names the port that owns the next response.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push, push_id: enqueue push_id (ignored when full unless popping too)
//   pop          : dequeue the head (ignored when empty)
//   full, empty  : occupancy status
//   head         : oldest stored ID
module core_mem_arb_id_fifo
  import core_mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push,
  input  port_id_e push_id,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output port_id_e head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  port_id_e         id_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = id_mem[rd_ptr];

  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        id_mem[wr_ptr] <= push_id;
        wr_ptr         <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
// Shares one single-ported OBI memory between the cv32e40p fetch and LSU
// ports. Arbitrates requests, forwards the winner's payload, remembers the
// owner of each accepted transaction and routes in-order responses back.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   instr_*             : fetch port (req/gnt/addr, rvalid/rdata)
//   data_*              : LSU port (req/gnt/we/be/addr/wdata, rvalid/rdata)
//   mem_*               : memory side (req/gnt/we/be/addr/wdata, rvalid/rdata)
//   proto_err_o         : sticky, a response arrived with nothing outstanding
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int DATA_PRIORITY   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    proto_err_o
);

  port_id_e sel;
  port_id_e last_winner;
  port_id_e head_id;
  logic     fifo_full;
  logic     fifo_empty;
  logic     pop;
  logic     can_issue;
  logic     accept;
  logic     proto_err_q;

  // A response only pops when there is something to pop; an orphan response
  // is flagged instead.
  assign pop = mem_rvalid_i & ~fifo_empty;

  // A full FIFO can still take a new ID when the head retires this cycle.
  assign can_issue = ~fifo_full | pop;

  // Tie-breaking: fixed mode favours data, round-robin favours whoever
  // did not win last time.
  always_comb begin
    sel = PORT_INSTR;
    if (data_req_i && !instr_req_i) begin
      sel = PORT_DATA;
    end else if (data_req_i && instr_req_i) begin
      if (DATA_PRIORITY == DATA_PRIO_FIXED) begin
        sel = PORT_DATA;
      end else begin
        sel = (last_winner == PORT_DATA) ? PORT_INSTR : PORT_DATA;
      end
    end
  end

  // Fetches are always full-word reads, so we and be are forced for INSTR.
  always_comb begin
    mem_addr_o  = instr_addr_i;
    mem_we_o    = 1'b0;
    mem_be_o    = '1;
    mem_wdata_o = '0;
    if (sel == PORT_DATA) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  assign mem_req_o   = ~rst_i & can_issue & (instr_req_i | data_req_i);
  assign accept      = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = accept & (sel == PORT_INSTR);
  assign data_gnt_o  = accept & (sel == PORT_DATA);

  assign instr_rvalid_o = ~rst_i & pop & (head_id == PORT_INSTR);
  assign data_rvalid_o  = ~rst_i & pop & (head_id == PORT_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign proto_err_o    = proto_err_q;

  // Winner history and the sticky protocol error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_winner <= PORT_DATA;
      proto_err_q <= 1'b0;
    end else begin
      if (accept) begin
        last_winner <= sel;
      end
      if (mem_rvalid_i && fifo_empty) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  core_mem_arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push   (accept),
    .push_id(sel),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head_id)
  );

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter
// Directed table of cycles plus randomized traffic for core_mem_arbiter.
// A second instance built with fixed data priority shares the inputs.
module tb_core_mem_arbiter;

  localparam int MAX_OUT = 2;
  localparam logic [31:0] I_ADDR = 32'h0000_0080;

  logic        clk;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        rr_igt, rr_dgt, rr_irv, rr_drv, rr_req, rr_we, rr_err;
  logic [31:0] rr_irdata, rr_drdata, rr_addr, rr_wdata;
  logic [3:0]  rr_be;
  logic        fp_igt, fp_dgt, fp_irv, fp_drv, fp_req, fp_we, fp_err;
  logic [31:0] fp_irdata, fp_drdata, fp_addr, fp_wdata;
  logic [3:0]  fp_be;

  int n_vectors;
  int n_miscompares;

  core_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAX_OUT), .DATA_PRIORITY(0)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(rr_igt), .instr_addr_i(instr_addr),
    .instr_rvalid_o(rr_irv), .instr_rdata_o(rr_irdata),
    .data_req_i(data_req), .data_gnt_o(rr_dgt), .data_we_i(data_we),
    .data_be_i(data_be), .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rvalid_o(rr_drv), .data_rdata_o(rr_drdata),
    .mem_req_o(rr_req), .mem_gnt_i(mem_gnt), .mem_we_o(rr_we), .mem_be_o(rr_be),
    .mem_addr_o(rr_addr), .mem_wdata_o(rr_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .proto_err_o(rr_err)
  );

  core_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAX_OUT), .DATA_PRIORITY(1)
  ) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(fp_igt), .instr_addr_i(instr_addr),
    .instr_rvalid_o(fp_irv), .instr_rdata_o(fp_irdata),
    .data_req_i(data_req), .data_gnt_o(fp_dgt), .data_we_i(data_we),
    .data_be_i(data_be), .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rvalid_o(fp_drv), .data_rdata_o(fp_drdata),
    .mem_req_o(fp_req), .mem_gnt_i(mem_gnt), .mem_we_o(fp_we), .mem_be_o(fp_be),
    .mem_addr_o(fp_addr), .mem_wdata_o(fp_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .proto_err_o(fp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ireq, dreq, gnt, rvalid, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        x_req, x_igt, x_dgt, x_irv, x_drv, x_err, chk_err, chk_pay, x_we;
    logic [3:0]  x_be;
    logic [31:0] x_addr, x_wdata;
  } vec_t;

  // Behavioural reference: outstanding owners as a queue (1 = data port).
  bit mq[$];
  bit m_last_data;
  bit m_err;
  bit e_req, e_igt, e_dgt, e_irv, e_drv, e_pick_data;

  function automatic vec_t row(input logic r, i, d, g, rv, input logic [31:0] rdata,
                               input logic xreq, xig, xdg, xirv, xdrv,
                               input logic chk_err, xerr);
    vec_t v;
    v.rst = r; v.ireq = i; v.dreq = d; v.gnt = g; v.rvalid = rv; v.rdata = rdata;
    v.we = 1'b0; v.be = 4'h0; v.addr = 32'h0000_0200; v.wdata = 32'h0;
    v.x_req = xreq; v.x_igt = xig; v.x_dgt = xdg; v.x_irv = xirv; v.x_drv = xdrv;
    v.chk_err = chk_err; v.x_err = xerr;
    v.chk_pay = 1'b0; v.x_we = 1'b0; v.x_be = 4'h0; v.x_addr = 32'h0; v.x_wdata = 32'h0;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    instr_req  = v.ireq;
    instr_addr = I_ADDR;
    data_req   = v.dreq;
    data_we    = v.we;
    data_be    = v.be;
    data_addr  = v.addr;
    data_wdata = v.wdata;
    mem_gnt    = v.gnt;
    mem_rvalid = v.rvalid;
    mem_rdata  = v.rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected combinational outputs for the current inputs and model state.
  task automatic modelEval();
    bit pop, full;
    full = (mq.size() >= MAX_OUT);
    pop  = mem_rvalid && (mq.size() > 0);
    if (instr_req && data_req) e_pick_data = !m_last_data;
    else                       e_pick_data = data_req;
    e_req = !rst && (instr_req || data_req) && (!full || pop);
    e_igt = e_req && mem_gnt && !e_pick_data;
    e_dgt = e_req && mem_gnt && e_pick_data;
    e_irv = 1'b0;
    e_drv = 1'b0;
    if (!rst && pop) begin
      e_irv = (mq[0] == 1'b0);
      e_drv = (mq[0] == 1'b1);
    end
  endtask

  task automatic modelAdvance();
    if (rst) begin
      mq.delete();
      m_last_data = 1'b1;
      m_err = 1'b0;
    end else begin
      if (mem_rvalid && mq.size() == 0) m_err = 1'b1;
      if (mem_rvalid && mq.size() > 0) void'(mq.pop_front());
      if (e_igt || e_dgt) begin
        mq.push_back(e_pick_data);
        m_last_data = e_pick_data;
      end
    end
  endtask

  task automatic driveCycle(input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #2;
    modelEval();
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    n_vectors = 0;
    n_miscompares = 0;
    m_last_data = 1'b1;
    m_err = 1'b0;

    // Reset with both requests high, then round-robin I,D,I,D.
    tbl.push_back(row(1,1,1,1,0, 32'h0,        0,0,0,0,0, 0,0));
    tbl.push_back(row(1,1,1,1,0, 32'h0,        0,0,0,0,0, 1,0));
    tbl.push_back(row(0,1,1,1,0, 32'h0,        1,1,0,0,0, 1,0));
    tbl.push_back(row(0,1,1,1,1, 32'h00150513, 1,0,1,1,0, 1,0));
    tbl.push_back(row(0,1,1,1,1, 32'h12345678, 1,1,0,0,1, 1,0));
    tbl.push_back(row(0,1,1,1,1, 32'h00150513, 1,0,1,1,0, 1,0));
    tbl.push_back(row(0,0,0,0,1, 32'hA5A5A5A5, 0,0,0,0,1, 1,0));
    // FIFO full: two accepts, three stalled cycles, push+pop on first response.
    v = row(0,1,0,1,0, 32'h0, 1,1,0,0,0, 1,0);
    v.chk_pay = 1; v.x_we = 0; v.x_be = 4'hF; v.x_addr = I_ADDR;
    tbl.push_back(v);
    tbl.push_back(row(0,0,1,1,0, 32'h0,        1,0,1,0,0, 1,0));
    tbl.push_back(row(0,1,0,1,0, 32'h0,        0,0,0,0,0, 1,0));
    tbl.push_back(row(0,1,0,1,0, 32'h0,        0,0,0,0,0, 1,0));
    tbl.push_back(row(0,1,0,1,0, 32'h0,        0,0,0,0,0, 1,0));
    tbl.push_back(row(0,1,0,1,1, 32'h0000_1111,1,1,0,1,0, 1,0));
    tbl.push_back(row(0,0,0,0,1, 32'h0000_2222,0,0,0,0,1, 1,0));
    tbl.push_back(row(0,0,0,0,1, 32'h0000_3333,0,0,0,1,0, 1,0));
    // Data write routing.
    v = row(0,0,1,1,0, 32'h0, 1,0,1,0,0, 1,0);
    v.we = 1; v.be = 4'b0011; v.addr = 32'h100; v.wdata = 32'hDEADBEEF;
    v.chk_pay = 1; v.x_we = 1; v.x_be = 4'b0011; v.x_addr = 32'h100; v.x_wdata = 32'hDEADBEEF;
    tbl.push_back(v);
    tbl.push_back(row(0,0,0,0,1, 32'h0,        0,0,0,0,1, 1,0));
    // Orphan response sets the sticky error until reset.
    tbl.push_back(row(0,0,0,0,1, 32'h0,        0,0,0,0,0, 1,0));
    tbl.push_back(row(0,0,0,0,0, 32'h0,        0,0,0,0,0, 1,1));
    tbl.push_back(row(0,1,0,1,0, 32'h0,        1,1,0,0,0, 1,1));
    tbl.push_back(row(0,0,0,0,1, 32'h0,        0,0,0,1,0, 1,1));
    tbl.push_back(row(1,0,0,0,0, 32'h0,        0,0,0,0,0, 1,1));
    tbl.push_back(row(0,0,0,0,0, 32'h0,        0,0,0,0,0, 1,0));

    for (int k = 0; k < tbl.size(); k++) begin
      driveCycle(tbl[k]);
      checkOutput($sformatf("row%0d mem_req", k), 32'(rr_req), 32'(tbl[k].x_req));
      checkOutput($sformatf("row%0d instr_gnt", k), 32'(rr_igt), 32'(tbl[k].x_igt));
      checkOutput($sformatf("row%0d data_gnt", k), 32'(rr_dgt), 32'(tbl[k].x_dgt));
      checkOutput($sformatf("row%0d instr_rvalid", k), 32'(rr_irv), 32'(tbl[k].x_irv));
      checkOutput($sformatf("row%0d data_rvalid", k), 32'(rr_drv), 32'(tbl[k].x_drv));
      checkOutput($sformatf("row%0d instr_rdata", k), rr_irdata, tbl[k].rdata);
      checkOutput($sformatf("row%0d data_rdata", k), rr_drdata, tbl[k].rdata);
      if (tbl[k].chk_err)
        checkOutput($sformatf("row%0d proto_err", k), 32'(rr_err), 32'(tbl[k].x_err));
      if (tbl[k].chk_pay) begin
        checkOutput($sformatf("row%0d mem_we", k), 32'(rr_we), 32'(tbl[k].x_we));
        checkOutput($sformatf("row%0d mem_be", k), 32'(rr_be), 32'(tbl[k].x_be));
        checkOutput($sformatf("row%0d mem_addr", k), rr_addr, tbl[k].x_addr);
        if (tbl[k].x_we)
          checkOutput($sformatf("row%0d mem_wdata", k), rr_wdata, tbl[k].x_wdata);
      end
      modelAdvance();
    end

    // Fixed data priority on the second instance: data wins every tie.
    begin
      vec_t fp_seq[6];
      logic [3:0] fp_exp[6];
      fp_seq[0] = row(1,0,0,0,0, 32'h0, 0,0,0,0,0, 0,0); fp_exp[0] = 4'b0000;
      fp_seq[1] = row(0,1,1,1,0, 32'h0, 0,0,0,0,0, 0,0); fp_exp[1] = 4'b0100;
      fp_seq[2] = row(0,1,1,1,1, 32'h0, 0,0,0,0,0, 0,0); fp_exp[2] = 4'b0101;
      fp_seq[3] = row(0,1,1,1,1, 32'h0, 0,0,0,0,0, 0,0); fp_exp[3] = 4'b0101;
      fp_seq[4] = row(0,1,0,1,1, 32'h0, 0,0,0,0,0, 0,0); fp_exp[4] = 4'b1001;
      fp_seq[5] = row(0,0,0,0,1, 32'h0, 0,0,0,0,0, 0,0); fp_exp[5] = 4'b0010;
      for (int k = 0; k < 6; k++) begin
        driveCycle(fp_seq[k]);
        checkOutput($sformatf("fp%0d {igt,dgt,irv,drv}", k),
                    32'({fp_igt, fp_dgt, fp_irv, fp_drv}), 32'(fp_exp[k]));
        modelAdvance();
      end
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      v = row(0,0,0,0,0, 32'h0, 0,0,0,0,0, 0,0);
      v.rst    = ($urandom_range(0, 99) == 0);
      v.ireq   = ($urandom_range(0, 2) != 0);
      v.dreq   = ($urandom_range(0, 2) != 0);
      v.gnt    = ($urandom_range(0, 3) != 0);
      v.rvalid = (mq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
      v.we     = $urandom_range(0, 1);
      v.be     = 4'($urandom);
      v.addr   = $urandom;
      v.wdata  = $urandom;
      v.rdata  = $urandom;
      driveCycle(v);
      checkOutput("rnd mem_req", 32'(rr_req), 32'(e_req));
      checkOutput("rnd instr_gnt", 32'(rr_igt), 32'(e_igt));
      checkOutput("rnd data_gnt", 32'(rr_dgt), 32'(e_dgt));
      checkOutput("rnd instr_rvalid", 32'(rr_irv), 32'(e_irv));
      checkOutput("rnd data_rvalid", 32'(rr_drv), 32'(e_drv));
      checkOutput("rnd data_rdata", rr_drdata, v.rdata);
      checkOutput("rnd proto_err", 32'(rr_err), 32'(m_err));
      if (!v.rst && (v.ireq || v.dreq)) begin
        checkOutput("rnd mem_addr", rr_addr, e_pick_data ? v.addr : I_ADDR);
        checkOutput("rnd mem_we", 32'(rr_we), 32'(e_pick_data & v.we));
        checkOutput("rnd mem_be", 32'(rr_be), e_pick_data ? 32'(v.be) : 32'hF);
        if (e_pick_data)
          checkOutput("rnd mem_wdata", rr_wdata, v.wdata);
      end
      modelAdvance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one single-ported OBI memory between the cv32e40p instruction-fetch and data (LSU) ports.
- Arbitrates requests, forwards the granted request to memory, and records the winner of each accepted transaction in an in-order ID FIFO.
- Routes each in-order memory response back to the correct core port.
- Sits between cv32e40p_core and the unified instruction/data SRAM in the core test harness.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, accepted-but-unanswered transactions tracked; ID FIFO depth; must be ≥ 1.
- DATA_PRIORITY, 0; 0 = round-robin, 1 = data port always wins ties.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  synchronous active-high reset.
- instr_req_i  in  1  fetch request.
- instr_gnt_o  out  1  fetch grant.
- instr_addr_i  in  ADDR_WIDTH  fetch address.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  DATA_WIDTH  fetch response data.
- data_req_i  in  1  LSU request.
- data_gnt_o  out  1  LSU grant.
- data_we_i  in  1  LSU write enable.
- data_be_i  in  DATA_WIDTH/8  LSU byte enables.
- data_addr_i  in  ADDR_WIDTH  LSU address.
- data_wdata_i  in  DATA_WIDTH  LSU write data.
- data_rvalid_o  out  1  LSU response valid (reads and writes).
- data_rdata_o  out  DATA_WIDTH  LSU read data.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  DATA_WIDTH/8  memory byte enables.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_rvalid_i  in  1  memory response valid; responses return in order.
- mem_rdata_i  in  DATA_WIDTH  memory response data.
- proto_err_o  out  1  sticky flag: response received with no outstanding ID.

Behaviour:
- Reset (rst_i high at a clock edge):
  - ID FIFO emptied.
  - last_winner <= DATA, so INSTR wins the first tie.
  - proto_err_o <= 0.
- While rst_i is high, all combinational outputs are forced low: mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o.
- Memory responses for pre-reset transactions are not routed. If one arrives after reset, it sets proto_err_o.
- Arbitration (combinational, zero latency):
  - can_issue = FIFO not full, or FIFO full with a pop this cycle (mem_rvalid_i high).
  - sel = DATA when only data_req_i is high.
  - sel = INSTR when only instr_req_i is high.
  - On a tie: DATA if DATA_PRIORITY=1, else the port that is not last_winner.
  - mem_req_o = can_issue & (instr_req_i | data_req_i).
  - Memory address, we, be and wdata are muxed from sel.
  - For INSTR: mem_we_o = 0 and mem_be_o = all ones.
- Accept: the granted port's *_gnt_o = mem_gnt_i & mem_req_o & (sel == port). The other port's grant is 0.
- On accept, sel is pushed into the ID FIFO and last_winner <= sel.
- A requester holds req and payload stable until granted. The arbiter re-evaluates sel every cycle. A held loser keeps req high and wins the next tie under round-robin.
- Response routing:
  - When mem_rvalid_i is high and the FIFO is non-empty, the head ID selects the port.
  - The selected port gets rvalid_o = 1 and rdata_o = mem_rdata_i in the same cycle. The FIFO pops.
  - instr_rdata_o and data_rdata_o always mirror mem_rdata_i; only the rvalids are gated.
- Response with an empty FIFO: no rvalid is asserted, proto_err_o <= 1, and it stays set until reset.
- Simultaneous push and pop: legal, including when the FIFO is full. Occupancy is unchanged.
- Minimum turnaround is 1 cycle from accept to response when memory rvalid follows gnt by one cycle. Back-to-back accepts every cycle are sustained when MAX_OUTSTANDING ≥ 2.
- No reordering and no request buffering inside the arbiter. Throughput is bounded only by mem_gnt_i and FIFO occupancy.

Decomposition:
- core_mem_arb_pkg holds:
  - typedef enum logic {PORT_INSTR, PORT_DATA} port_id_e;
  - localparam DATA_PRIO_RR = 0, DATA_PRIO_FIXED = 1.
- Sub-module core_mem_arb_id_fifo:
  - Parameterised depth, storing port_id_e.
  - Ports: push, pop, full, empty, head.
  - Pointer wrap-around and occupancy counter.
  - Synchronous active-high reset.
- Top level contains the arbitration logic, payload mux, response demux and error flag.

Test Plan:
- Reset: rst_i=1 for 2 cycles with both reqs high → all gnt, rvalid and mem_req_o = 0. After release, the first tie grants INSTR; proto_err_o = 0.
- Round-robin: both reqs held high, mem_gnt_i=1, 1-cycle memory → grants alternate I,D,I,D over 4 cycles.
  - Expected response order: rvalid on the instr, data, instr, data ports.
  - instr_rdata_o = 0x00150513 on each instr response.
- Fixed priority (DATA_PRIORITY=1): both reqs high for 3 cycles → data_gnt_o every cycle, instr_gnt_o stays 0 until data_req_i drops.
- FIFO full: MAX_OUTSTANDING=2, memory stalls rvalid for 3 cycles after 2 accepts.
  - mem_req_o = 0 and no grants while the FIFO is full.
  - On the cycle the first rvalid arrives, a new accept occurs (simultaneous push/pop).
- Write routing: data write addr=0x100, be=4'b0011, wdata=0xDEADBEEF → mem_we_o=1, mem_be_o=0011 in the grant cycle; data_rvalid_o asserted 1 cycle later.
- Protocol error: mem_rvalid_i pulsed with an empty FIFO → no rvalid_o; proto_err_o=1 and stays set until rst_i.
